ans_bcd_display: RTL and testbench



---
 rtl/ans_bcd_display_if.sv | 21 ++
 rtl/ans_bcd_display.sv | 136 +++++++++++++
 tb/tb_ans_bcd_display.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ans_bcd_display_if.sv
// ans_bcd_display_if: result bus and display bundle for the BCD display stage.
//   ans     : unsigned result from the operation selector (WIDTH bits)
//   on_off  : calculator power switch, 0 blanks all displays
//   hex0..2 : active-low seven-segment digits (ones, tens, hundreds), bit0=a..bit6=g
//   busy    : conversion in progress
//   valid   : at least one conversion completed since reset
// master = the block driving the result bus; slave = the display stage.
interface ans_bcd_display_if #(parameter int WIDTH = 7);
  logic [WIDTH-1:0] ans;
  logic             on_off;
  logic [6:0]       hex0;
  logic [6:0]       hex1;
  logic [6:0]       hex2;
  logic             busy;
  logic             valid;

  modport master (output ans, output on_off,
                  input hex0, input hex1, input hex2, input busy, input valid);
  modport slave  (input ans, input on_off,
                  output hex0, output hex1, output hex2, output busy, output valid);
endinterface

// File: rtl/ans_bcd_display.sv
// ans_bcd_display: converts the calculator result to three decimal digits with a
// sequential shift-add-3 engine and drives three active-low seven-segment displays
// with leading-zero blanking. Only fully converted values ever reach the displays.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ans_bcd_display_if.slave (ans, on_off in; hex0/1/2, busy, valid out)
module ans_bcd_display #(
  parameter int WIDTH = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  ans_bcd_display_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_ans_q;
  logic             r_on_q;
  logic [WIDTH-1:0] r_shown;
  logic [WIDTH-1:0] r_cap;
  logic             r_pending;
  logic [WIDTH-1:0] r_bin;
  logic [11:0]      r_bcd;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_d2, r_d1, r_d0;
  logic             r_busy;
  logic             r_valid;
  logic [6:0]       r_hex0, r_hex1, r_hex2;

  // Add-3 on the ones and tens nibbles. With at most 9 input bits the hundreds
  // nibble is <= 2 before any shift, so it never needs the correction.
  logic [7:0]       w_adj_lo;

  always_comb begin
    w_adj_lo = r_bcd[7:0];
    for (int i = 0; i < 2; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj_lo[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Conversion FSM; busy/valid are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ans_q   <= '0;
      r_on_q    <= 1'b0;
      r_shown   <= '0;
      r_cap     <= '0;
      r_pending <= 1'b1;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_d2      <= '0;
      r_d1      <= '0;
      r_d0      <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_ans_q <= bus.ans;
      r_on_q  <= bus.on_off;
      case (r_state)
        IDLE: begin
          if (r_pending || (r_ans_q != r_shown)) begin
            r_bin   <= r_ans_q;
            r_cap   <= r_ans_q;
            r_bcd   <= '0;
            r_cnt   <= CW'(WIDTH);
            r_state <= CONV;
            r_busy  <= 1'b1;
          end
        end
        CONV: begin
          r_bcd <= {r_bcd[10:8], w_adj_lo, r_bin[WIDTH-1]};
          r_bin <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= DONE;
        end
        DONE: begin
          r_d2      <= r_bcd[11:8];
          r_d1      <= r_bcd[7:4];
          r_d0      <= r_bcd[3:0];
          r_shown   <= r_cap;
          r_pending <= 1'b0;
          r_valid   <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage reads only the committed digit registers, never the engine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex0 <= 7'h7F;
      r_hex1 <= 7'h7F;
      r_hex2 <= 7'h7F;
    end else if (!r_on_q) begin
      r_hex0 <= 7'h7F;
      r_hex1 <= 7'h7F;
      r_hex2 <= 7'h7F;
    end else begin
      r_hex0 <= seg7(r_d0);
      r_hex1 <= (r_d2 == 4'd0 && r_d1 == 4'd0) ? 7'h7F : seg7(r_d1);
      r_hex2 <= (r_d2 == 4'd0) ? 7'h7F : seg7(r_d2);
    end
  end

  assign bus.hex0  = r_hex0;
  assign bus.hex1  = r_hex1;
  assign bus.hex2  = r_hex2;
  assign bus.busy  = r_busy;
  assign bus.valid = r_valid;
endmodule

// File: tb/tb_ans_bcd_display.sv
module tb_ans_bcd_display;
  localparam int W = 7;

  // Expected display triples {hex2, hex1, hex0}
  localparam logic [20:0] D0   = {7'h7F, 7'h7F, 7'b1000000};
  localparam logic [20:0] D127 = {7'b1111001, 7'b0100100, 7'b1111000};
  localparam logic [20:0] D105 = {7'b1111001, 7'b1000000, 7'b0010010};
  localparam logic [20:0] D7   = {7'h7F, 7'h7F, 7'b1111000};
  localparam logic [20:0] D45  = {7'h7F, 7'b0011001, 7'b0010010};
  localparam logic [20:0] D99  = {7'h7F, 7'b0010000, 7'b0010000};
  localparam logic [20:0] DOFF = {7'h7F, 7'h7F, 7'h7F};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ans_bcd_display_if #(.WIDTH(W)) bus ();
  ans_bcd_display #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  // Background observation of busy and of every distinct display value
  int          busy_hi, busy_rise, last_gap, low_run;
  logic        busy_prev;
  logic [20:0] last_disp;
  logic [20:0] hist[$];
  logic [20:0] disp;
  assign disp = {bus.hex2, bus.hex1, bus.hex0};

  always @(negedge clk) begin
    if (bus.busy) begin
      busy_hi++;
      if (!busy_prev) begin
        busy_rise++;
        last_gap = low_run;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    busy_prev = bus.busy;
    if (disp != last_disp) begin
      hist.push_back(disp);
      last_disp = disp;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    busy_hi   = 0;
    busy_rise = 0;
    last_gap  = -1;
    low_run   = 0;
    busy_prev = bus.busy;
    last_disp = disp;
    hist.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ans = '0;
    bus.on_off = 1'b1;
    clr_mon();
    step(3);
    n_cmp++; if (disp !== DOFF) begin n_fail++; $display("FAIL reset_hex: got %h want %h", disp, DOFF); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    rst_n = 1'b1;
    step(11);
    n_cmp++; if (disp !== D0) begin n_fail++; $display("FAIL first_conv_hex: got %h want %h", disp, D0); end
    n_cmp++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL first_conv_valid: got %b want 1", bus.valid); end
    step(5);
  endtask

  // Latency: display changes exactly at the 11th edge (N+10) after driving 127
  task automatic test_latency();
    clr_mon();
    bus.ans = 7'd127;
    step(10);
    n_cmp++; if (disp !== D0) begin n_fail++; $display("FAIL lat_early: got %h want %h", disp, D0); end
    step(1);
    n_cmp++; if (disp !== D127) begin n_fail++; $display("FAIL lat_update: got %h want %h", disp, D127); end
    step(10);
    n_cmp++; if (busy_hi !== 8) begin n_fail++; $display("FAIL busy_len_127: got %0d want 8", busy_hi); end
    n_cmp++; if (busy_rise !== 1) begin n_fail++; $display("FAIL busy_rise_127: got %0d want 1", busy_rise); end
  endtask

  task automatic test_convert(input logic [W-1:0] v, input logic [20:0] exp_d, input string name);
    clr_mon();
    bus.ans = v;
    step(20);
    n_cmp++; if (disp !== exp_d) begin n_fail++; $display("FAIL %s_hex: got %h want %h", name, disp, exp_d); end
    n_cmp++; if (busy_hi !== W + 1) begin n_fail++; $display("FAIL %s_busy_len: got %0d want %0d", name, busy_hi, W + 1); end
    n_cmp++; if (hist.size() !== 1) begin n_fail++; $display("FAIL %s_changes: got %0d want 1", name, hist.size()); end
  endtask

  task automatic test_back_to_back();
    clr_mon();
    bus.ans = 7'd45;
    step(4);            // edge N samples, N+1 enters CONV, N+2/N+3 are CONV edges
    bus.ans = 7'd99;
    step(30);
    n_cmp++; if (disp !== D99) begin n_fail++; $display("FAIL b2b_final: got %h want %h", disp, D99); end
    n_cmp++; if (hist.size() !== 2) begin n_fail++; $display("FAIL b2b_nvals: got %0d want 2", hist.size()); end
    if (hist.size() == 2) begin
      n_cmp++; if (hist[0] !== D45) begin n_fail++; $display("FAIL b2b_first: got %h want %h", hist[0], D45); end
      n_cmp++; if (hist[1] !== D99) begin n_fail++; $display("FAIL b2b_second: got %h want %h", hist[1], D99); end
    end
    n_cmp++; if (busy_rise !== 2) begin n_fail++; $display("FAIL b2b_rises: got %0d want 2", busy_rise); end
    n_cmp++; if (last_gap !== 1) begin n_fail++; $display("FAIL b2b_gap: got %0d want 1", last_gap); end
    n_cmp++; if (busy_hi !== 2 * (W + 1)) begin n_fail++; $display("FAIL b2b_busy_len: got %0d want %0d", busy_hi, 2 * (W + 1)); end
  endtask

  task automatic test_on_off();
    bus.ans = 7'd45;
    step(20);
    n_cmp++; if (disp !== D45) begin n_fail++; $display("FAIL onoff_pre: got %h want %h", disp, D45); end
    clr_mon();
    bus.on_off = 1'b0;
    step(1);
    n_cmp++; if (disp !== D45) begin n_fail++; $display("FAIL off_edge1: got %h want %h", disp, D45); end
    step(1);
    n_cmp++; if (disp !== DOFF) begin n_fail++; $display("FAIL off_edge2: got %h want %h", disp, DOFF); end
    step(5);
    bus.on_off = 1'b1;
    step(2);
    n_cmp++; if (disp !== D45) begin n_fail++; $display("FAIL on_restore: got %h want %h", disp, D45); end
    step(10);
    n_cmp++; if (busy_rise !== 0) begin n_fail++; $display("FAIL onoff_busy: got %0d want 0", busy_rise); end
  endtask

  task automatic test_reset_mid();
    bus.ans = 7'd105;
    step(4);            // conversion of 105 is now in CONV
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #2;
    n_cmp++; if (disp !== DOFF) begin n_fail++; $display("FAIL mid_rst_hex: got %h want %h", disp, DOFF); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", bus.valid); end
    step(2);
    rst_n = 1'b1;
    step(30);
    n_cmp++; if (disp !== D105) begin n_fail++; $display("FAIL mid_after: got %h want %h", disp, D105); end
    n_cmp++; if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid: got %b want 1", bus.valid); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_convert(7'd105, D105, "v105");
    test_convert(7'd7, D7, "v7");
    test_convert(7'd127, D127, "v127");
    test_back_to_back();
    test_on_off();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
